det_sched: RTL and testbench
============================

DET_SCHED -- requirements
Module: det_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing the detector.
REQ-002 The block SHALL have parameter WIDTH, default 8, bits per job word.
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_b  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  N_REQ  per-requester job request, held until acked.
REQ-006 The block SHALL have port req_data  input  N_REQ*WIDTH  job words, slice i belongs to req[i].
REQ-007 The block SHALL have port ack  output  N_REQ  one-hot, one-cycle pulse when a job is accepted.
REQ-008 The block SHALL have port resp_valid  output  1  one-cycle pulse when a job result is ready.
REQ-009 The block SHALL have port resp_id  output  clog2(N_REQ)  index of the requester owning the result.
REQ-010 The block SHALL have port resp_count  output  clog2(WIDTH+1)  number of detector hits for the job.
REQ-011 The block SHALL have port det_in  output  1  serial bit driven to the shared FSM detector's In.
REQ-012 The block SHALL have port det_reset_b  output  1  active-low clear driven to the detector's reset_b.
REQ-013 The block SHALL have port det_out  input  1  the detector's Out.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, SHIFT, DRAIN and DONE.
REQ-015 In IDLE with any req set, the arbiter SHALL pick a winner; on the edge, the FSM latches the winner index and word, then moves to CLEAR.
REQ-016 ack[winner] SHALL be 1 for exactly the CLEAR cycle; ack SHALL be 0 in all other states.
REQ-017 In CLEAR, det_reset_b SHALL be 0 for one cycle; det_in SHALL be 0.
REQ-018 SHIFT SHALL last WIDTH cycles; in SHIFT cycle k (0..WIDTH-1), det_in SHALL equal word bit k (LSB first).
REQ-019 DRAIN SHALL last one cycle with det_in = 0.
REQ-020 det_out SHALL be sampled in SHIFT cycles 1..WIDTH-1 and in DRAIN, giving WIDTH samples; each 1 increments the hit counter, which is cleared in CLEAR.
REQ-021 In DONE, resp_valid SHALL be 1, resp_id SHALL be the latched index and resp_count the counter; the FSM then returns to IDLE.
REQ-022 Latency SHALL be fixed: resp_valid asserts WIDTH+3 cycles after the IDLE cycle that sampled req.
REQ-023 Arbitration SHALL be round-robin: after serving i, requester (i+1) mod N_REQ has highest priority; the pointer wraps from N_REQ-1 to 0.
REQ-024 req changes outside IDLE SHALL be ignored; a req still high in IDLE after its ack SHALL start a new job.
REQ-025 resp_count SHALL saturate at WIDTH and never wrap.

Reset
REQ-026 Asserting reset_b at any time, including mid-job, SHALL force IDLE immediately and abort the job without a response.
REQ-027 During reset: ack=0, resp_valid=0, resp_id=0, resp_count=0, det_in=0, det_reset_b=0, and the round-robin pointer = 0.
REQ-028 Outside reset, det_reset_b SHALL be 1 except in CLEAR.

Configuration
REQ-029 With DET_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the pointer SHALL not exist.
REQ-030 Without DET_SCHED_FIXED_PRIO_EN, round-robin per REQ-023 SHALL apply.

Structure
REQ-031 Package det_sched_pkg SHALL hold the state encoding, the default N_REQ/WIDTH constants, and the count-width and id-width constants.
REQ-032 Arbitration SHALL live in one sub-module, det_rr_arbiter (req vector and pointer in, one-hot grant and index out).

Verification
Each scenario SHALL use a stub detector with det_out equal to det_in registered and cleared by det_reset_b, so resp_count equals the popcount of the word.
REQ-033 Reset, then req[2]=1 with word 8'hB5 -> ack[2] in the cycle after; resp_valid 11 cycles after req sampled, resp_id=2, resp_count=5.
REQ-034 Word 8'h00 from req[0], then 8'hFF from req[0] -> counts 0, then 8, with no saturation overflow.
REQ-035 req[0..3] all held high continuously -> service order 0,1,2,3,0; with DET_SCHED_FIXED_PRIO_EN defined -> 0,0,0.
REQ-036 reset_b pulsed low during SHIFT cycle 3 -> no resp_valid, all outputs at their reset values; the next req is served from pointer 0.
REQ-037 req[1] toggled during SHIFT of req[3]'s job -> ignored; after DONE, if req[1] is high in IDLE, it is acked next.

Source files
------------

// File: rtl/det_sched_pkg.sv
// Shared constants, width helpers and FSM state encoding for det_sched.
package det_sched_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;

    // Requester index width; at least one bit so a single requester still has an id.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hit-count width: must hold values 0..w inclusive.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DEF_ID_W  = id_w(DEF_N_REQ);
    localparam int unsigned DEF_CNT_W = cnt_w(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/det_sched_if.sv
// Requester/response bus between the job sources and det_sched.
//   req/req_data : per-requester job request and word (driven by master)
//   ack          : one-hot accept pulse (driven by slave)
//   resp_*       : result pulse, owner index and hit count (driven by slave)
interface det_sched_if #(
    parameter int unsigned N_REQ = det_sched_pkg::DEF_N_REQ,
    parameter int unsigned WIDTH = det_sched_pkg::DEF_WIDTH
);
    import det_sched_pkg::*;

    localparam int unsigned ID_W  = id_w(N_REQ);
    localparam int unsigned CNT_W = cnt_w(WIDTH);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   resp_valid;
    logic [ID_W-1:0]        resp_id;
    logic [CNT_W-1:0]       resp_count;

    modport master (
        output req, req_data,
        input  ack, resp_valid, resp_id, resp_count
    );

    modport slave (
        input  req, req_data,
        output ack, resp_valid, resp_id, resp_count
    );

endinterface

// File: rtl/det_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : index holding highest priority this cycle
//   grant_c : one-hot grant, idx_c : granted index, any_c : some request present
// A ptr tied to zero turns this into a lowest-index-wins fixed-priority arbiter.
module det_rr_arbiter #(
    parameter int unsigned N_REQ = det_sched_pkg::DEF_N_REQ,
    parameter int unsigned ID_W  = det_sched_pkg::DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  idx_c,
    output logic             any_c
);

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        int unsigned j;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        j       = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            j = (32'(ptr) + off) % N_REQ;
            if (!any_c && req[ID_W'(j)]) begin
                grant_c[ID_W'(j)] = 1'b1;
                idx_c             = ID_W'(j);
                any_c             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/det_sched.sv
// Time-shares one serial pattern detector between N_REQ requesters.
// Each accepted job clears the detector, shifts its word in LSB first,
// counts detector hits and reports the count with the owner's index.
//   clock, reset_b : clock and asynchronous active-low reset
//   bus            : det_sched_if slave (req/req_data in, ack/resp_* out)
//   det_in         : serial bit to the detector
//   det_reset_b    : active-low clear to the detector
//   det_out        : detector output
// Build option: DET_SCHED_FIXED_PRIO_EN selects lowest-index-wins arbitration
// and removes the round-robin pointer.
module det_sched #(
    parameter int unsigned N_REQ = det_sched_pkg::DEF_N_REQ,
    parameter int unsigned WIDTH = det_sched_pkg::DEF_WIDTH
) (
    input  logic      clock,
    input  logic      reset_b,
    det_sched_if.slave bus,
    output logic      det_in,
    output logic      det_reset_b,
    input  logic      det_out
);
    import det_sched_pkg::*;

    localparam int unsigned ID_W  = id_w(N_REQ);
    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_e             state_q, state_n;
    logic [ID_W-1:0]    id_q, id_n;
    logic [WIDTH-1:0]   word_q, word_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [N_REQ-1:0]   ack_q, ack_n;
    logic               valid_q, valid_n;
    logic [ID_W-1:0]    rid_q, rid_n;
    logic [CNT_W-1:0]   rcnt_q, rcnt_n;
    logic               din_q, din_n;
    logic               clr_q, clr_n;
    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   grant_c;
    logic [ID_W-1:0]    gidx_c;
    logic               any_c;

`ifdef DET_SCHED_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0]    ptr_q, ptr_n;
    assign ptr = ptr_q;
`endif

    det_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .grant_c (grant_c),
        .idx_c   (gidx_c),
        .any_c   (any_c)
    );

    // Hit counter never wraps past WIDTH.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
        return (hit && (c != CNT_MAX)) ? c + 1'b1 : c;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_n = state_q;
        id_n    = id_q;
        word_n  = word_q;
        bit_n   = bit_q;
        cnt_n   = cnt_q;
        ack_n   = '0;
        valid_n = 1'b0;
        rid_n   = rid_q;
        rcnt_n  = rcnt_q;
        din_n   = 1'b0;
        clr_n   = 1'b0;
`ifndef DET_SCHED_FIXED_PRIO_EN
        ptr_n   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_n = CLEAR;
                    id_n    = gidx_c;
                    ack_n   = grant_c;
                    clr_n   = 1'b1;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (gidx_c == ID_W'(i)) begin
                            word_n = bus.req_data[i*WIDTH +: WIDTH];
                        end
                    end
`ifndef DET_SCHED_FIXED_PRIO_EN
                    ptr_n = (gidx_c == ID_W'(N_REQ - 1)) ? '0 : gidx_c + 1'b1;
`endif
                end
            end
            CLEAR: begin
                state_n = SHIFT;
                bit_n   = '0;
                cnt_n   = '0;
                din_n   = word_q[0];
            end
            SHIFT: begin
                // det_out lags det_in by one cycle, so shift cycle 0 carries no hit.
                if (bit_q != '0) begin
                    cnt_n = sat_inc(cnt_q, det_out);
                end
                if (bit_q == LAST_BIT) begin
                    state_n = DRAIN;
                end else begin
                    bit_n = bit_q + 1'b1;
                    din_n = word_q[bit_n];
                end
            end
            DRAIN: begin
                state_n = DONE;
                valid_n = 1'b1;
                rid_n   = id_q;
                rcnt_n  = sat_inc(cnt_q, det_out);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            id_q    <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            rid_q   <= '0;
            rcnt_q  <= '0;
            din_q   <= 1'b0;
            clr_q   <= 1'b0;
`ifndef DET_SCHED_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            id_q    <= id_n;
            word_q  <= word_n;
            bit_q   <= bit_n;
            cnt_q   <= cnt_n;
            ack_q   <= ack_n;
            valid_q <= valid_n;
            rid_q   <= rid_n;
            rcnt_q  <= rcnt_n;
            din_q   <= din_n;
            clr_q   <= clr_n;
`ifndef DET_SCHED_FIXED_PRIO_EN
            ptr_q   <= ptr_n;
`endif
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = rid_q;
    assign bus.resp_count = rcnt_q;
    assign det_in         = din_q;
    // Gated with reset_b so the detector is held clear while the scheduler is in reset.
    assign det_reset_b    = reset_b & ~clr_q;

endmodule

// File: tb/tb_det_sched.sv
// Self-checking bench for det_sched with a register-stub detector
// (det_out = det_in delayed one cycle, cleared by det_reset_b).
module tb_det_sched;
    import det_sched_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clock;
    logic reset_b;
    logic det_in;
    logic det_reset_b;
    logic det_out;

    logic [W-1:0] words_now  [N];
    logic [W-1:0] words_next [N];

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    det_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

    det_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .bus         (bus),
        .det_in      (det_in),
        .det_reset_b (det_reset_b),
        .det_out     (det_out)
    );

    for (genvar g = 0; g < N; g++) begin : g_data
        assign bus.req_data[g*W +: W] = words_now[g];
    end

    always_ff @(posedge clock or negedge det_reset_b) begin
        if (!det_reset_b) det_out <= 1'b0;
        else              det_out <= det_in;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference arbitration: among set requests, the one closest to the
    // priority pointer going upward (mod N) wins.
    function automatic int pick(input logic [N-1:0] r, input int p);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - p + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int next_ptr(input int served);
`ifdef DET_SCHED_FIXED_PRIO_EN
        return 0 + (served - served);
`else
        return (served + 1) % N;
`endif
    endfunction

    task automatic rand_next_words();
        for (int i = 0; i < N; i++) words_next[i] = W'($urandom);
    endtask

    // One complete job, starting from an IDLE cycle with req already driven.
    // junk is driven mid-shift, fin late in shift (with words_next) so that fin
    // is what the following IDLE cycle samples.
    task automatic do_job(input string tag, input int exp_id,
                          input logic [N-1:0] junk, input logic [N-1:0] fin);
        int waited;
        logic [W-1:0] w;
        w = words_now[exp_id];
        waited = 0;
        do begin
            step();
            waited++;
        end while (bus.ack == '0 && waited < 20);
        check({tag, ":ack_latency"}, 32'(waited), 32'd1);
        check({tag, ":ack_onehot"}, 32'(bus.ack), 32'd1 << exp_id);
        check({tag, ":clear_det_reset_b"}, 32'(det_reset_b), 32'd0);
        check({tag, ":clear_det_in"}, 32'(det_in), 32'd0);
        m_ptr = next_ptr(exp_id);
        for (int k = 0; k < W; k++) begin
            step();
            check({tag, ":shift_det_in"}, 32'(det_in), 32'(w[k]));
            check({tag, ":shift_det_reset_b"}, 32'(det_reset_b), 32'd1);
            check({tag, ":shift_ack"}, 32'(bus.ack), 32'd0);
            check({tag, ":shift_resp_valid"}, 32'(bus.resp_valid), 32'd0);
            if (k == 2) bus.req = junk;
            if (k == W - 1) begin
                bus.req = fin;
                for (int i = 0; i < N; i++) words_now[i] = words_next[i];
            end
        end
        step();
        check({tag, ":drain_det_in"}, 32'(det_in), 32'd0);
        check({tag, ":drain_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        step();
        check({tag, ":done_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, ":done_resp_id"}, 32'(bus.resp_id), 32'(exp_id));
        check({tag, ":done_resp_count"}, 32'(bus.resp_count), 32'($countones(w)));
        check({tag, ":done_ack"}, 32'(bus.ack), 32'd0);
        step();
        check({tag, ":idle_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ":idle_det_reset_b"}, 32'(det_reset_b), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":ack"}, 32'(bus.ack), 32'd0);
        check({tag, ":resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ":resp_id"}, 32'(bus.resp_id), 32'd0);
        check({tag, ":resp_count"}, 32'(bus.resp_count), 32'd0);
        check({tag, ":det_in"}, 32'(det_in), 32'd0);
        check({tag, ":det_reset_b"}, 32'(det_reset_b), 32'd0);
    endtask

    initial begin
        int exp_id;
        int waited;
        int seen;
        logic [N-1:0] r;
        logic [N-1:0] junk;
        logic [N-1:0] fin;

        reset_b = 1'b1;
        bus.req = '0;
        for (int i = 0; i < N; i++) begin
            words_now[i]  = '0;
            words_next[i] = '0;
        end
        #3 reset_b = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset_b = 1'b1;
        step();
        check("post_reset_det_reset_b", 32'(det_reset_b), 32'd1);
        check("post_reset_idle_ack", 32'(bus.ack), 32'd0);

        // Single job from requester 2, word B5 -> 5 hits.
        words_now[2] = 8'hB5;
        rand_next_words();
        bus.req = 4'b0100;
        exp_id = pick(bus.req, m_ptr);
        check("b5_model_winner", 32'(exp_id), 32'd2);
        do_job("b5", exp_id, 4'b0100, 4'b0000);

        // Empty and full words from requester 0 -> 0 then WIDTH hits.
        words_now[0] = 8'h00;
        rand_next_words();
        words_next[0] = 8'hFF;
        bus.req = 4'b0001;
        do_job("w00", pick(bus.req, m_ptr), 4'b0001, 4'b0001);
        rand_next_words();
        do_job("wff", pick(bus.req, m_ptr), 4'b0001, 4'b0000);

        // Serve requester 3 so the rotation below starts at 0.
        rand_next_words();
        bus.req = 4'b1000;
        do_job("pre_all", pick(bus.req, m_ptr), 4'b1000, 4'b0000);

        // All requesters held: 0,1,2,3,0 (fixed priority: 0 every time).
        rand_next_words();
        for (int i = 0; i < N; i++) words_now[i] = words_next[i];
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_id = pick(bus.req, m_ptr);
`ifdef DET_SCHED_FIXED_PRIO_EN
            check("all_held_order", 32'(exp_id), 32'd0);
`else
            check("all_held_order", 32'(exp_id), 32'(j % N));
`endif
            rand_next_words();
            do_job("all_held", exp_id, 4'b1111, (j == 4) ? 4'b0000 : 4'b1111);
        end

        // req[1] toggled during requester 3's shift is ignored; high at IDLE -> next.
        rand_next_words();
        bus.req = 4'b1000;
        do_job("toggle_r3", pick(bus.req, m_ptr), 4'b1010, 4'b0010);
        exp_id = pick(bus.req, m_ptr);
        check("toggle_next_winner", 32'(exp_id), 32'd1);
        rand_next_words();
        do_job("toggle_r1", exp_id, 4'b0011, 4'b0000);

        // Abort mid-shift with reset; pointer must restart at 0.
        bus.req = 4'b0110;
        exp_id = pick(bus.req, m_ptr);
        waited = 0;
        do begin
            step();
            waited++;
        end while (bus.ack == '0 && waited < 20);
        check("abort_ack", 32'(bus.ack), 32'd1 << exp_id);
        m_ptr = next_ptr(exp_id);
        for (int k = 0; k < 4; k++) step();
        reset_b = 1'b0;
        bus.req = '0;
        #1;
        check_reset_outputs("abort_reset");
        m_ptr = 0;
        step();
        step();
        reset_b = 1'b1;
        seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            step();
            if (bus.resp_valid !== 1'b0 || bus.ack !== '0) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        check("abort_det_reset_b", 32'(det_reset_b), 32'd1);
        rand_next_words();
        for (int i = 0; i < N; i++) words_now[i] = words_next[i];
        bus.req = 4'b1010;
        exp_id = pick(bus.req, m_ptr);
        check("abort_ptr_restart", 32'(exp_id), 32'd1);
        rand_next_words();
        do_job("after_abort", exp_id, 4'b1010, 4'b0000);

        // Randomized traffic against the reference arbiter and popcount.
        rand_next_words();
        for (int i = 0; i < N; i++) words_now[i] = words_next[i];
        r = N'($urandom_range(1, (1 << N) - 1));
        bus.req = r;
        for (int j = 0; j < 24; j++) begin
            exp_id = pick(bus.req, m_ptr);
            junk = N'($urandom);
            fin  = (j == 23) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            rand_next_words();
            do_job("random", exp_id, junk, fin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
